fb_ctrl: RTL
============

FB_CTRL -- requirements
Module: fb_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, buffer address width (1024 entries per bank).
REQ-002 Parameter DATA_W, default 12, pixel width (4:4:4 RGB).
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 vsync  in  1  one-cycle pulse at start of display vertical blank.
REQ-006 rd_req  in  1  display scanout read request, no backpressure.
REQ-007 rd_addr  in  ADDR_W  scanout pixel address.
REQ-008 rd_valid  out  1  rd_data holds the read result this cycle.
REQ-009 rd_data  out  DATA_W  front-bank pixel data.
REQ-010 wr_valid  in  1  renderer write request.
REQ-011 wr_ready  out  1  controller accepts the write this cycle.
REQ-012 wr_addr  in  ADDR_W  renderer pixel address.
REQ-013 wr_data  in  DATA_W  renderer pixel data.
REQ-014 frame_done  in  1  one-cycle pulse: renderer has finished the back-bank frame.
REQ-015 buf_en  out  1  double-buffer enable.
REQ-016 buf_swap_en  out  1  double-buffer bank swap request.
REQ-017 buf_w_en  out  1  double-buffer write enable (back bank).
REQ-018 buf_addr  out  ADDR_W  double-buffer shared address.
REQ-019 buf_din  out  DATA_W  double-buffer write data.
REQ-020 buf_dout  in  DATA_W  double-buffer front-bank read data (1-cycle latency).
REQ-021 swap_done  out  1  one-cycle pulse in the cycle after a swap is issued.
REQ-022 miss_cnt  out  8  count of vsyncs that found no finished frame.

Function
REQ-023 States: RENDER, WAIT_VSYNC, SWAP; one access slot (read, write or swap) per cycle.
REQ-024 Read has absolute priority: rd_req=1 grants read; buf_en=1, buf_w_en=0, buf_addr=rd_addr.
REQ-025 rd_valid is rd_req registered (latency 1); rd_data is buf_dout passed through combinationally.
REQ-026 wr_ready = (state==RENDER) & ~rd_req; wr_ready is independent of wr_valid.
REQ-027 Write accepted iff wr_valid & wr_ready; then buf_en=1, buf_w_en=1, buf_addr=wr_addr, buf_din=wr_data.
REQ-028 Unaccepted writes are held by the renderer; the controller never drops or buffers a write.
REQ-029 RENDER: frame_done & ~vsync -> WAIT_VSYNC; frame_done & vsync (same cycle) -> SWAP.
REQ-030 RENDER: vsync & ~frame_done -> stay in RENDER and increment miss_cnt, saturating at 255.
REQ-031 WAIT_VSYNC: wr_ready=0; vsync -> SWAP; frame_done is ignored.
REQ-032 SWAP: if ~rd_req, issue buf_en=1, buf_swap_en=1, buf_w_en=0 for exactly one cycle, then -> RENDER.
REQ-033 SWAP with rd_req=1: the read is served, the swap is deferred, and the state remains SWAP.
REQ-034 buf_swap_en is never asserted in the same cycle as a read or write grant.
REQ-035 swap_done pulses one cycle after buf_swap_en.
REQ-036 frame_done while in SWAP is ignored.
REQ-037 When idle, buf_en=0; buf_addr and buf_din are don't-care but are driven from rd_addr/wr_addr/wr_data mux (no X).

Reset
REQ-038 On rst: state=RENDER, miss_cnt=0, rd_valid=0, swap_done=0, buf_en=0, buf_w_en=0, buf_swap_en=0.
REQ-039 rst is not propagated to the double buffer; bank contents and bank select are unaffected.
REQ-040 rst mid-SWAP cancels any pending swap; no buf_swap_en pulse follows reset.

Verification
REQ-041 After reset, wr_valid=1 with wr_addr=5, wr_data=0xABC, rd_req=0 -> buf_w_en=1, buf_addr=5, buf_din=0xABC the same cycle, wr_ready=1.
REQ-042 rd_req=1 rd_addr=7 together with wr_valid=1 -> wr_ready=0, buf_addr=7, buf_w_en=0; next cycle rd_valid=1, rd_data=buf_dout.
REQ-043 frame_done pulse, then vsync 10 cycles later -> WAIT_VSYNC with wr_ready=0 for 10 cycles; buf_swap_en exactly one cycle after vsync; swap_done the following cycle; then wr_ready=1.
REQ-044 Enter SWAP with rd_req held high for 3 cycles -> no buf_swap_en during those cycles; buf_swap_en in the 4th cycle.
REQ-045 300 vsync pulses without frame_done -> miss_cnt stops at 255; frame_done and vsync in the same cycle -> SWAP, with miss_cnt unchanged.
REQ-046 rst asserted in SWAP while rd_req=1 -> buf_swap_en never asserts; state=RENDER, miss_cnt=0 after reset.

Source files
------------

// File: rtl/fb_ctrl_if.sv
// Renderer/scanout side of the frame-buffer controller: the read and write ports.
interface fb_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Clients: scanout reader and renderer
    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_data, wr_ready
    );

    // Controller side
    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_valid, rd_data, wr_ready
    );
endinterface

// File: rtl/fb_ctrl.sv
// Double-buffer frame controller: arbitrates one buffer slot per cycle between
// scanout reads (highest priority), renderer writes and the vsync-aligned bank swap.
module fb_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    fb_ctrl_if.slave          bus,
    input  logic              vsync_i,
    input  logic              frame_done_i,
    output logic              buf_en_o,
    output logic              buf_swap_en_o,
    output logic              buf_w_en_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [DATA_W-1:0] buf_din_o,
    input  logic [DATA_W-1:0] buf_dout_i,
    output logic              swap_done_o,
    output logic [7:0]        miss_cnt_o
);

    typedef enum logic [1:0] {RENDER, WAIT_VSYNC, SWAP} state_t;

    state_t     state_q, state_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic       rd_valid_q;
    logic       swap_done_q;
    logic       rd_grant, wr_ready, wr_grant, swap_grant;

    // Next-state, miss counting and slot grants; grants are held off while rst is
    // high so the buffer sees no access and no swap during reset.
    always_comb begin
        state_d    = state_q;
        miss_cnt_d = miss_cnt_q;
        rd_grant   = bus.rd_req & ~rst;
        wr_ready   = (state_q == RENDER) & ~bus.rd_req & ~rst;
        wr_grant   = bus.wr_valid & wr_ready;
        swap_grant = 1'b0;
        case (state_q)
            RENDER: begin
                if (frame_done_i) begin
                    state_d = vsync_i ? SWAP : WAIT_VSYNC;
                end else if (vsync_i && miss_cnt_q != 8'hFF) begin
                    miss_cnt_d = miss_cnt_q + 8'd1;
                end
            end
            WAIT_VSYNC: begin
                if (vsync_i) state_d = SWAP;
            end
            SWAP: begin
                // A read owns the slot; the swap waits for the first free cycle.
                if (!bus.rd_req) begin
                    swap_grant = ~rst;
                    state_d    = RENDER;
                end
            end
            default: state_d = RENDER;
        endcase
    end

    // State, miss counter and one-cycle-delayed read/swap status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RENDER;
            miss_cnt_q  <= 8'd0;
            rd_valid_q  <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_cnt_q  <= miss_cnt_d;
            rd_valid_q  <= bus.rd_req;
            swap_done_q <= swap_grant;
        end
    end

    assign buf_en_o      = rd_grant | wr_grant | swap_grant;
    assign buf_w_en_o    = wr_grant;
    assign buf_swap_en_o = swap_grant;
    assign buf_addr_o    = bus.rd_req ? bus.rd_addr : bus.wr_addr;
    assign buf_din_o     = bus.wr_data;
    assign bus.rd_data   = buf_dout_i;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_ready  = wr_ready;
    assign swap_done_o   = swap_done_q;
    assign miss_cnt_o    = miss_cnt_q;

endmodule
